// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a word-addressed PC through instruction memory.
// The stage can hold one returned word while the hazard unit stalls, and it
// accepts branch/jump redirects. Fetched data is presented in the same cycle
// that memory returns it.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jumpTaken,
    input  logic [31:0] jumpTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] pcPlusOneOut,
    output logic [31:0] instructionOut,
    output logic        fetchValid,
    output logic        ifidWriteEnable,
    output logic        ifidFlush
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} fetchState_t;

    fetchState_t state, stateNext;
    logic [31:0] pc, pcNext, holdReg, holdNext, pcPlusOne, redirectTarget;
    logic        redirect;

    // The adder wraps naturally at 2^32.
    assign pcPlusOne      = pc + 32'd1;
    assign redirect       = branchTaken | jumpTaken;
    // A branch wins when both redirects arrive together.
    assign redirectTarget = branchTaken ? branchTarget : jumpTarget;

    // State, PC and held-word registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            holdReg <= 32'h0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            holdReg <= holdNext;
        end
    end

    // Next-state and output decode; redirects win over stall and imemReady.
    always_comb begin
        stateNext       = state;
        pcNext          = pc;
        holdNext        = holdReg;
        imemReq         = 1'b0;
        imemAddr        = pc;
        fetchValid      = 1'b0;
        ifidWriteEnable = 1'b0;
        ifidFlush       = 1'b0;
        instructionOut  = 32'h0;
        pcPlusOneOut    = pcPlusOne;
        if (Reset) begin
            unique case (state)
                BOOT: stateNext = FETCH;
                FETCH: begin
                    imemReq = 1'b1;
                    if (redirect) begin
                        // Any outstanding request is abandoned here.
                        ifidFlush = 1'b1;
                        pcNext    = redirectTarget;
                    end else if (imemReady) begin
                        fetchValid     = 1'b1;
                        instructionOut = imemData;
                        if (!stall) begin
                            ifidWriteEnable = 1'b1;
                            pcNext          = pcPlusOne;
                        end else begin
                            holdNext  = imemData;
                            stateNext = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        ifidFlush = 1'b1;
                        pcNext    = redirectTarget;
                        holdNext  = 32'h0;
                        stateNext = FETCH;
                    end else begin
                        fetchValid     = 1'b1;
                        instructionOut = holdReg;
                        if (!stall) begin
                            // The held word is consumed; no re-read of memory.
                            ifidWriteEnable = 1'b1;
                            pcNext          = pcPlusOne;
                            stateNext       = FETCH;
                        end
                    end
                end
                default: stateNext = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by a random run
// that is checked against a cycle-level reference model.
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        Reset, stall, branchTaken, jumpTaken, imemReady;
    logic [31:0] branchTarget, jumpTarget, imemData;
    logic        imemReq, fetchValid, ifidWriteEnable, ifidFlush;
    logic [31:0] imemAddr, pcPlusOneOut, instructionOut;

    int nChecks = 0;
    int nFails  = 0;

    instruction_fetch dut (
        .Clk(Clk), .Reset(Reset), .stall(stall),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jumpTaken(jumpTaken), .jumpTarget(jumpTarget),
        .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemData(imemData),
        .pcPlusOneOut(pcPlusOneOut), .instructionOut(instructionOut),
        .fetchValid(fetchValid), .ifidWriteEnable(ifidWriteEnable),
        .ifidFlush(ifidFlush)
    );

    always #5 Clk = ~Clk;

    // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drv(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic rdy, input logic [31:0] data);
        @(negedge Clk);
        Reset = rst; stall = stl; branchTaken = br; branchTarget = bt;
        jumpTaken = jp; jumpTarget = jt; imemReady = rdy; imemData = data;
        #1;
    endtask

    task automatic test_reset();
        drv(0, 1, 1, 32'h55, 1, 32'h66, 1, 32'h1234);
        drv(0, 1, 1, 32'h55, 1, 32'h66, 1, 32'h1234);
        nChecks++;
        if ({imemReq, fetchValid, ifidWriteEnable, ifidFlush} !== 4'b0 || instructionOut !== 32'h0) begin
            nFails++;
            $display("FAIL reset_outputs: req/fv/we/flush=%b instr=%h, required 0000 and 0",
                     {imemReq, fetchValid, ifidWriteEnable, ifidFlush}, instructionOut);
        end
        drv(1, 0, 1, 32'h55, 0, 32'h0, 1, 32'h1234);
        nChecks++;
        if (imemReq !== 1'b0 || fetchValid !== 1'b0 || ifidFlush !== 1'b0 || pcPlusOneOut !== 32'h1) begin
            nFails++;
            $display("FAIL boot_cycle: req=%b fv=%b flush=%b pc1=%h, required 0 0 0 00000001",
                     imemReq, fetchValid, ifidFlush, pcPlusOneOut);
        end
    endtask

    // Stream from PC 0 with data = addr+0x100; keeps going up to PC 5.
    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0, 0, 1, i + 32'h100);
            nChecks++;
            if (imemReq !== 1'b1 || imemAddr !== i || fetchValid !== 1'b1 || ifidWriteEnable !== 1'b1 ||
                instructionOut !== i + 32'h100 || pcPlusOneOut !== i + 1) begin
                nFails++;
                $display("FAIL stream_%0d: req=%b addr=%h fv=%b we=%b instr=%h pc1=%h, required 1 %h 1 1 %h %h",
                         i, imemReq, imemAddr, fetchValid, ifidWriteEnable, instructionOut, pcPlusOneOut,
                         i, i + 32'h100, i + 1);
            end
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0, 0, 0, 0, 0, 32'hBAD0BAD0);
            nChecks++;
            if (imemReq !== 1'b1 || imemAddr !== 32'd5 || fetchValid !== 1'b0 || ifidWriteEnable !== 1'b0 ||
                instructionOut !== 32'h0 || pcPlusOneOut !== 32'd6) begin
                nFails++;
                $display("FAIL wait_%0d: req=%b addr=%h fv=%b we=%b instr=%h pc1=%h, required 1 5 0 0 0 6",
                         i, imemReq, imemAddr, fetchValid, ifidWriteEnable, instructionOut, pcPlusOneOut);
            end
        end
        drv(1, 0, 0, 0, 0, 0, 1, 32'h105);
        nChecks++;
        if (fetchValid !== 1'b1 || ifidWriteEnable !== 1'b1 || instructionOut !== 32'h105 || pcPlusOneOut !== 32'd6) begin
            nFails++;
            $display("FAIL wait_release: fv=%b we=%b instr=%h pc1=%h, required 1 1 105 6",
                     fetchValid, ifidWriteEnable, instructionOut, pcPlusOneOut);
        end
    endtask

    task automatic test_stall();
        drv(1, 0, 0, 0, 0, 0, 1, 32'h106);
        drv(1, 0, 0, 0, 0, 0, 1, 32'h107);
        drv(1, 1, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        nChecks++;
        if (imemAddr !== 32'd8 || fetchValid !== 1'b1 || ifidWriteEnable !== 1'b0 || instructionOut !== 32'hDEADBEEF) begin
            nFails++;
            $display("FAIL stall_capture: addr=%h fv=%b we=%b instr=%h, required 8 1 0 deadbeef",
                     imemAddr, fetchValid, ifidWriteEnable, instructionOut);
        end
        drv(1, 1, 0, 0, 0, 0, 1, 32'h0BADF00D);
        nChecks++;
        if (imemReq !== 1'b0 || imemAddr !== 32'd8 || fetchValid !== 1'b1 || ifidWriteEnable !== 1'b0 ||
            instructionOut !== 32'hDEADBEEF) begin
            nFails++;
            $display("FAIL stall_hold: req=%b addr=%h fv=%b we=%b instr=%h, required 0 8 1 0 deadbeef",
                     imemReq, imemAddr, fetchValid, ifidWriteEnable, instructionOut);
        end
        drv(1, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        nChecks++;
        if (imemReq !== 1'b0 || ifidWriteEnable !== 1'b1 || instructionOut !== 32'hDEADBEEF || pcPlusOneOut !== 32'd9) begin
            nFails++;
            $display("FAIL stall_release: req=%b we=%b instr=%h pc1=%h, required 0 1 deadbeef 9",
                     imemReq, ifidWriteEnable, instructionOut, pcPlusOneOut);
        end
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        nChecks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'd9) begin
            nFails++;
            $display("FAIL stall_resume: req=%b addr=%h, required 1 9", imemReq, imemAddr);
        end
    endtask

    task automatic test_redirect();
        drv(1, 1, 0, 0, 0, 0, 1, 32'h109);
        drv(1, 1, 1, 32'd40, 1, 32'd80, 1, 32'h0);
        nChecks++;
        if (ifidFlush !== 1'b1 || fetchValid !== 1'b0 || ifidWriteEnable !== 1'b0 || instructionOut !== 32'h0) begin
            nFails++;
            $display("FAIL redirect_hold: flush=%b fv=%b we=%b instr=%h, required 1 0 0 0",
                     ifidFlush, fetchValid, ifidWriteEnable, instructionOut);
        end
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        nChecks++;
        if (ifidFlush !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'd40) begin
            nFails++;
            $display("FAIL redirect_target: flush=%b req=%b addr=%h, required 0 1 28", ifidFlush, imemReq, imemAddr);
        end
        // Jump abandons an outstanding wait.
        drv(1, 1, 0, 0, 1, 32'd100, 0, 32'h0);
        nChecks++;
        if (ifidFlush !== 1'b1 || fetchValid !== 1'b0) begin
            nFails++;
            $display("FAIL jump_wait: flush=%b fv=%b, required 1 0", ifidFlush, fetchValid);
        end
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        nChecks++;
        if (imemAddr !== 32'd100 || ifidFlush !== 1'b0) begin
            nFails++;
            $display("FAIL jump_target: addr=%h flush=%b, required 64 0", imemAddr, ifidFlush);
        end
    endtask

    task automatic test_wrap();
        drv(1, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 32'h0);
        drv(1, 0, 0, 0, 0, 0, 1, 32'hCAFE0001);
        nChecks++;
        if (imemAddr !== 32'hFFFFFFFF || pcPlusOneOut !== 32'h0 || instructionOut !== 32'hCAFE0001) begin
            nFails++;
            $display("FAIL wrap_fetch: addr=%h pc1=%h instr=%h, required ffffffff 0 cafe0001",
                     imemAddr, pcPlusOneOut, instructionOut);
        end
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        nChecks++;
        if (imemAddr !== 32'h0) begin
            nFails++;
            $display("FAIL wrap_next: addr=%h, required 00000000", imemAddr);
        end
    endtask

    task automatic test_mid_reset();
        drv(1, 0, 1, 32'd12, 0, 0, 0, 32'h0);
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        drv(0, 1, 1, 32'd77, 0, 0, 1, 32'h99);
        nChecks++;
        if ({imemReq, fetchValid, ifidWriteEnable, ifidFlush} !== 4'b0 || instructionOut !== 32'h0) begin
            nFails++;
            $display("FAIL midreset_outputs: req/fv/we/flush=%b instr=%h, required 0000 0",
                     {imemReq, fetchValid, ifidWriteEnable, ifidFlush}, instructionOut);
        end
        drv(1, 0, 0, 0, 0, 0, 1, 32'h99);
        nChecks++;
        if (imemReq !== 1'b0 || fetchValid !== 1'b0 || pcPlusOneOut !== 32'h1) begin
            nFails++;
            $display("FAIL midreset_boot: req=%b fv=%b pc1=%h, required 0 0 1", imemReq, fetchValid, pcPlusOneOut);
        end
        drv(1, 0, 0, 0, 0, 0, 0, 32'h0);
        nChecks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
            nFails++;
            $display("FAIL midreset_fetch: req=%b addr=%h, required 1 0", imemReq, imemAddr);
        end
    endtask

    // Random traffic against a model that tracks the PC, whether a word is
    // parked, and whether the first post-reset cycle is still pending.
    task automatic test_random();
        logic [31:0] mPc = 32'h0, mHeld = 32'h0;
        bit          mBooting = 1'b1, mParked = 1'b0;
        logic        rst, stl, br, jp, rdy;
        logic [31:0] bt, jt, data;
        logic        eReq, eFv, eWe, eFl;
        logic [31:0] eInstr;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(39) != 0);
            stl  = ($urandom_range(9) < 3);
            br   = ($urandom_range(11) == 0);
            jp   = ($urandom_range(11) == 0);
            rdy  = ($urandom_range(9) < 7);
            bt   = $urandom; jt = $urandom; data = $urandom;
            if ($urandom_range(7) == 0) bt = 32'hFFFFFFFF;
            drv(rst, stl, br, bt, jp, jt, rdy, data);
            eReq = 0; eFv = 0; eWe = 0; eFl = 0; eInstr = 32'h0;
            if (rst && !mBooting) begin
                eReq = !mParked;
                if (br || jp) eFl = 1;
                else if (mParked) begin eFv = 1; eInstr = mHeld; eWe = !stl; end
                else if (rdy) begin eFv = 1; eInstr = data; eWe = !stl; end
            end
            nChecks++;
            if ({imemReq, fetchValid, ifidWriteEnable, ifidFlush} !== {eReq, eFv, eWe, eFl} ||
                instructionOut !== eInstr ||
                (rst && (imemAddr !== mPc || pcPlusOneOut !== mPc + 32'd1))) begin
                nFails++;
                $display("FAIL random_%0d: req/fv/we/fl=%b instr=%h addr=%h pc1=%h, required %b %h %h %h",
                         c, {imemReq, fetchValid, ifidWriteEnable, ifidFlush}, instructionOut, imemAddr,
                         pcPlusOneOut, {eReq, eFv, eWe, eFl}, eInstr, mPc, mPc + 32'd1);
            end
            // Advance the model across the coming edge.
            if (!rst) begin
                mPc = 32'h0; mHeld = 32'h0; mBooting = 1; mParked = 0;
            end else if (mBooting) begin
                mBooting = 0;
            end else if (br || jp) begin
                mPc = br ? bt : jt; mParked = 0;
            end else if (eFv && !stl) begin
                mPc = mPc + 32'd1; mParked = 0;
            end else if (eFv && stl && !mParked) begin
                mParked = 1; mHeld = data;
            end
        end
    endtask

    initial begin
        Reset = 0; stall = 0; branchTaken = 0; jumpTaken = 0; imemReady = 0;
        branchTarget = 0; jumpTarget = 0; imemData = 0;
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_redirect();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
